// File: rtl/sie_pkg.sv
// Shared definitions for the SIE OUT data receive path: FSM states and CRC16 constants.
package sie_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RX,
    ST_ABORT
  } rx_state_e;

  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY_REF = 16'hA001;
  // Register value left after a packet whose appended CRC16 is intact.
  localparam logic [15:0] CRC16_RESIDUAL = 16'hB001;

endpackage

// File: rtl/sie_out_data_rx_if.sv
// Bundle of PHY receive, OUT FIFO and handshake signals around sie_out_data_rx.
interface sie_out_data_rx_if;

  logic       pkt_start_i;
  logic [7:0] rx_data_i;
  logic       rx_valid_i;
  logic       rx_eop_i;
  logic       rx_err_i;
  logic [7:0] out_data_o;
  logic       out_valid_o;
  logic       out_err_o;
  logic       out_ready_o;
  logic       out_nak_i;
  logic       hs_ack_o;
  logic       hs_nak_o;

  modport slave (
    input  pkt_start_i, rx_data_i, rx_valid_i, rx_eop_i, rx_err_i, out_nak_i,
    output out_data_o, out_valid_o, out_err_o, out_ready_o, hs_ack_o, hs_nak_o
  );

  modport master (
    output pkt_start_i, rx_data_i, rx_valid_i, rx_eop_i, rx_err_i, out_nak_i,
    input  out_data_o, out_valid_o, out_err_o, out_ready_o, hs_ack_o, hs_nak_o
  );

endinterface

// File: rtl/crc16_byte.sv
// Combinational CRC16 update over one byte, reflected polynomial, LSB of the byte first.
module crc16_byte
  import sie_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  always_comb begin
    crc_o = crc_i;
    for (int i = 0; i < 8; i++) begin
      if (crc_o[0] ^ data_i[i])
        crc_o = (crc_o >> 1) ^ CRC16_POLY_REF;
      else
        crc_o = crc_o >> 1;
    end
  end

endmodule

// File: rtl/sie_out_data_rx.sv
// OUT data stage: strips CRC16 via a 2-byte hold delay, forwards payload, raises EOP/error strobes.
// Define SIE_OUT_LEN_CHECK_EN to abort packets longer than OUT_MAXPACKETSIZE payload bytes.
module sie_out_data_rx
  import sie_pkg::*;
#(
  parameter int OUT_MAXPACKETSIZE = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clk_gate_i,
  sie_out_data_rx_if.slave  bus
);

  localparam int CNT_MAX = OUT_MAXPACKETSIZE + 3;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  rx_state_e        state;
  logic [CNT_W-1:0] byte_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [15:0]      crc;
  logic [15:0]      crc_next;
  logic [7:0]       hold_old;
  logic [7:0]       hold_new;
  logic             len_over;
  logic             eop_good;
  logic             rx_fault;

  crc16_byte u_crc16_byte (
    .crc_i  (crc),
    .data_i (bus.rx_data_i),
    .crc_o  (crc_next)
  );

  assign cnt_next = (byte_cnt == CNT_W'(CNT_MAX)) ? byte_cnt : byte_cnt + CNT_W'(1);
  assign eop_good = (byte_cnt >= CNT_W'(2)) && (crc == CRC16_RESIDUAL);
  assign rx_fault = bus.pkt_start_i || bus.rx_err_i || (bus.rx_valid_i && bus.rx_eop_i);

`ifdef SIE_OUT_LEN_CHECK_EN
  assign len_over = cnt_next > CNT_W'(OUT_MAXPACKETSIZE + 2);
`else
  assign len_over = 1'b0;
`endif

  // Every output is a one-gate-period pulse, so all strobes default low on each gate tick.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= ST_IDLE;
      byte_cnt        <= '0;
      crc             <= CRC16_INIT;
      hold_old        <= 8'h00;
      hold_new        <= 8'h00;
      bus.out_data_o  <= 8'h00;
      bus.out_valid_o <= 1'b0;
      bus.out_err_o   <= 1'b0;
      bus.out_ready_o <= 1'b0;
      bus.hs_ack_o    <= 1'b0;
      bus.hs_nak_o    <= 1'b0;
    end else if (clk_gate_i) begin
      bus.out_valid_o <= 1'b0;
      bus.out_err_o   <= 1'b0;
      bus.out_ready_o <= 1'b0;
      bus.hs_ack_o    <= 1'b0;
      bus.hs_nak_o    <= 1'b0;
      case (state)
        ST_IDLE, ST_ABORT: begin
          if (bus.pkt_start_i) begin
            state    <= ST_RX;
            byte_cnt <= '0;
            crc      <= CRC16_INIT;
            hold_old <= 8'h00;
            hold_new <= 8'h00;
          end else if (state == ST_ABORT && bus.rx_eop_i) begin
            state <= ST_IDLE;
          end
        end
        ST_RX: begin
          if (rx_fault) begin
            bus.out_err_o   <= 1'b1;
            bus.out_ready_o <= 1'b1;
            state           <= ST_ABORT;
          end else if (bus.rx_eop_i) begin
            bus.out_ready_o <= 1'b1;
            bus.out_err_o   <= !eop_good;
            bus.hs_ack_o    <= eop_good && !bus.out_nak_i;
            bus.hs_nak_o    <= eop_good && bus.out_nak_i;
            state           <= ST_IDLE;
          end else if (bus.rx_valid_i) begin
            crc      <= crc_next;
            byte_cnt <= cnt_next;
            hold_old <= hold_new;
            hold_new <= bus.rx_data_i;
            if (len_over) begin
              bus.out_err_o   <= 1'b1;
              bus.out_ready_o <= 1'b1;
              state           <= ST_ABORT;
            end else if (byte_cnt >= CNT_W'(2)) begin
              // Oldest held byte is now known not to be part of the trailing CRC16.
              bus.out_data_o  <= hold_old;
              bus.out_valid_o <= 1'b1;
              bus.out_ready_o <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sie_out_data_rx.sv
// Scoreboard bench for sie_out_data_rx: directed packets push expected strobes, a monitor pops them.
// Expectations for the oversize packet follow SIE_OUT_LEN_CHECK_EN.
module tb_sie_out_data_rx;

  localparam int MAX_PKT = 8;

  typedef struct {
    int         gate;
    logic [7:0] data;
    logic       valid;
    logic       err;
    logic       ack;
    logic       nak;
  } exp_t;

  logic clk_i      = 1'b0;
  logic rst_i      = 1'b1;
  logic clk_gate_i = 1'b0;
  logic done       = 1'b0;

  int   errors   = 0;
  int   checks   = 0;
  int   drv_gate = 0;
  int   mon_gate = 0;
  exp_t exp_q[$];
  logic [7:0] pkt_buf [0:15];

  sie_out_data_rx_if bus ();

  sie_out_data_rx #(.OUT_MAXPACKETSIZE(MAX_PKT)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clk_gate_i (clk_gate_i),
    .bus        (bus)
  );

  always #5 clk_i = ~clk_i;

  // One gate period: three idle clocks, then one clock with the gate high and the given inputs.
  task automatic apply_stimulus(input logic rst, input logic ps, input logic [7:0] d,
                                input logic v, input logic eop, input logic er);
    repeat (3) begin
      @(negedge clk_i);
      rst_i           = rst;
      clk_gate_i      = 1'b0;
      bus.pkt_start_i = 1'b0;
      bus.rx_data_i   = 8'h00;
      bus.rx_valid_i  = 1'b0;
      bus.rx_eop_i    = 1'b0;
      bus.rx_err_i    = 1'b0;
    end
    @(negedge clk_i);
    rst_i           = rst;
    clk_gate_i      = 1'b1;
    bus.pkt_start_i = ps;
    bus.rx_data_i   = d;
    bus.rx_valid_i  = v;
    bus.rx_eop_i    = eop;
    bus.rx_err_i    = er;
    drv_gate++;
  endtask

  task automatic push_exp(input logic [7:0] d, input logic v, input logic e,
                          input logic a, input logic n);
    exp_t x;
    x.gate  = drv_gate;
    x.data  = d;
    x.valid = v;
    x.err   = e;
    x.ack   = a;
    x.nak   = n;
    exp_q.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] d);
    apply_stimulus(1'b0, 1'b0, d, 1'b1, 1'b0, 1'b0);
  endtask

  function automatic logic [15:0] crc16_model(input int n);
    logic [15:0] c = 16'hFFFF;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 8; b++)
        c = (c[0] ^ pkt_buf[i][b]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    return c;
  endfunction

  // Sends pkt_buf[0:n-1] plus its CRC16; payload byte k strobes at the gate of wire byte k+2.
  task automatic send_packet(input int n, input logic nak, input logic flip_crc,
                             input logic expect_len_err);
    logic [7:0]  w [0:15];
    logic [15:0] crc;
    logic        aborted = 1'b0;
    crc = ~crc16_model(n);
    for (int i = 0; i < n; i++) w[i] = pkt_buf[i];
    w[n]     = crc[7:0];
    w[n + 1] = crc[15:8] ^ (flip_crc ? 8'h80 : 8'h00);
    bus.out_nak_i = nak;
    apply_stimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n + 2; i++) begin
      send_byte(w[i]);
      if (!aborted && expect_len_err && i == MAX_PKT + 2) begin
        push_exp(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        aborted = 1'b1;
      end else if (!aborted && i >= 2) begin
        push_exp(w[i - 2], 1'b1, 1'b0, 1'b0, 1'b0);
      end
    end
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    if (!aborted) begin
      if (flip_crc) push_exp(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      else          push_exp(8'h00, 1'b0, 1'b0, !nak, nak);
    end
    idle(2);
  endtask

  // Compares the outputs registered at gate edge mon_gate against the scoreboard.
  task automatic check_output();
    exp_t e;
    while (exp_q.size() != 0 && exp_q[0].gate < mon_gate) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL missed_strobe: no out_ready_o seen, required one at gate %0d (data=%h valid=%b err=%b)",
               e.gate, e.data, e.valid, e.err);
    end
    if (rst_i) begin
      checks++;
      if ({bus.out_data_o, bus.out_valid_o, bus.out_err_o, bus.out_ready_o, bus.hs_ack_o, bus.hs_nak_o} != 13'h0) begin
        errors++;
        $display("[TB] FAIL reset_outputs gate %0d: got data=%h valid=%b err=%b ready=%b ack=%b nak=%b, required all 0",
                 mon_gate, bus.out_data_o, bus.out_valid_o, bus.out_err_o, bus.out_ready_o, bus.hs_ack_o, bus.hs_nak_o);
      end
    end else if (bus.out_ready_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_strobe gate %0d: got data=%h valid=%b err=%b ack=%b nak=%b, required no strobe",
                 mon_gate, bus.out_data_o, bus.out_valid_o, bus.out_err_o, bus.hs_ack_o, bus.hs_nak_o);
      end else begin
        e = exp_q.pop_front();
        if (e.gate != mon_gate || bus.out_valid_o != e.valid || bus.out_err_o != e.err ||
            bus.hs_ack_o != e.ack || bus.hs_nak_o != e.nak || (e.valid && bus.out_data_o != e.data)) begin
          errors++;
          $display("[TB] FAIL %s: got gate=%0d data=%h valid=%b err=%b ack=%b nak=%b, required gate=%0d data=%h valid=%b err=%b ack=%b nak=%b",
                   e.valid ? "byte_strobe" : (e.err ? "err_strobe" : "eop_strobe"),
                   mon_gate, bus.out_data_o, bus.out_valid_o, bus.out_err_o, bus.hs_ack_o, bus.hs_nak_o,
                   e.gate, e.data, e.valid, e.err, e.ack, e.nak);
        end
      end
    end else if (bus.out_valid_o || bus.out_err_o || bus.hs_ack_o || bus.hs_nak_o) begin
      checks++;
      errors++;
      $display("[TB] FAIL stray_output gate %0d: got valid=%b err=%b ack=%b nak=%b without out_ready_o, required all 0",
               mon_gate, bus.out_valid_o, bus.out_err_o, bus.hs_ack_o, bus.hs_nak_o);
    end
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk_i);
      if (done) begin
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("[TB] FAIL pending_expect: got %0d unmatched expected strobes, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
      if (clk_gate_i) begin
        mon_gate++;
        #1;
        check_output();
      end
    end
  end

  initial begin : stimulus
    bus.pkt_start_i = 1'b0;
    bus.rx_data_i   = 8'h00;
    bus.rx_valid_i  = 1'b0;
    bus.rx_eop_i    = 1'b0;
    bus.rx_err_i    = 1'b0;
    bus.out_nak_i   = 1'b0;

    repeat (3) apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    idle(1);

    $display("[TB] idle ignores rx_valid/rx_eop/rx_err");
    send_byte(8'h55);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(1);

    $display("[TB] zero length packet");
    send_packet(0, 1'b0, 1'b0, 1'b0);

    $display("[TB] payload 00 01 02 03");
    for (int i = 0; i < 4; i++) pkt_buf[i] = 8'(i);
    send_packet(4, 1'b0, 1'b0, 1'b0);

    $display("[TB] payload with corrupted CRC");
    send_packet(4, 1'b0, 1'b1, 1'b0);

    $display("[TB] rx_err after two bytes");
    bus.out_nak_i = 1'b0;
    apply_stimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    send_byte(8'h11);
    send_byte(8'h22);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    push_exp(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    idle(1);
    send_packet(0, 1'b0, 1'b0, 1'b0);

    $display("[TB] NAK at good EOP");
    pkt_buf[0] = 8'hA5;
    pkt_buf[1] = 8'h5A;
    pkt_buf[2] = 8'h3C;
    send_packet(3, 1'b1, 1'b0, 1'b0);

    $display("[TB] oversize payload of 9 bytes");
    for (int i = 0; i < 9; i++) pkt_buf[i] = 8'(8'h10 + i);
`ifdef SIE_OUT_LEN_CHECK_EN
    send_packet(9, 1'b0, 1'b0, 1'b1);
`else
    send_packet(9, 1'b0, 1'b0, 1'b0);
`endif

    $display("[TB] rx_valid with rx_eop");
    bus.out_nak_i = 1'b0;
    apply_stimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    send_byte(8'h11);
    send_byte(8'h22);
    apply_stimulus(1'b0, 1'b0, 8'h33, 1'b1, 1'b1, 1'b0);
    push_exp(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    idle(1);

    $display("[TB] pkt_start inside a packet, then restart from abort");
    apply_stimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    send_byte(8'h11);
    send_byte(8'h22);
    apply_stimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    push_exp(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    send_byte(8'h66);
    send_packet(0, 1'b0, 1'b0, 1'b0);

    $display("[TB] EOP after one byte");
    apply_stimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    send_byte(8'h7E);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    push_exp(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);

    $display("[TB] reset in the middle of a packet");
    apply_stimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    push_exp(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    send_byte(8'h04);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    idle(1);
    send_packet(0, 1'b0, 1'b0, 1'b0);

    idle(2);
    @(negedge clk_i);
    done = 1'b1;
  end

endmodule
